// File: rtl/rv32_loader_pkg.sv
// Shared types and framing constants for the instruction memory loader.
`default_nettype none

package rv32_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } loader_state_t;

    localparam int LDR_HDR_BYTES  = 4;
    localparam int LDR_WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
// Host byte link, instruction memory write port and status bundle of the loader.
`default_nettype none

interface instr_mem_loader_if #(
    parameter int MEM_SIZE = 16384
);
    localparam int ADDR_SIZE = $clog2(MEM_SIZE);

    logic                 Load_Start;
    logic                 Load_Abort;
    logic [7:0]           Byte_In;
    logic                 Byte_Valid;
    logic                 Byte_Ready;
    logic                 Wr_En;
    logic [ADDR_SIZE-1:0] Wr_Addr;
    logic [31:0]          Wr_Data;
    logic                 Core_Hold;
    logic                 Load_Busy;
    logic                 Load_Done;
    logic                 Load_Err;

    modport master (
        output Load_Start, Load_Abort, Byte_In, Byte_Valid,
        input  Byte_Ready, Wr_En, Wr_Addr, Wr_Data,
        input  Core_Hold, Load_Busy, Load_Done, Load_Err
    );

    modport slave (
        input  Load_Start, Load_Abort, Byte_In, Byte_Valid,
        output Byte_Ready, Wr_En, Wr_Addr, Wr_Data,
        output Core_Hold, Load_Busy, Load_Done, Load_Err
    );

endinterface

`default_nettype wire

// File: rtl/instr_word_packer.sv
// Little-endian byte-to-word packer; Word_Out is the completed word in the cycle Word_Full is high.
`default_nettype none

module instr_word_packer
    import rv32_loader_pkg::*;
(
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic        Clear,
    input  logic [7:0]  Byte_In,
    input  logic        Byte_Take,
    output logic [31:0] Word_Out,
    output logic        Word_Full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shreg_q, shreg_d;

    // Only three bytes of history are kept; the fourth is taken straight from the input.
    assign Word_Out  = {Byte_In, shreg_q};
    assign Word_Full = Byte_Take && (cnt_q == 2'(LDR_WORD_BYTES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (Clear) begin
            cnt_d = 2'd0;
        end else if (Byte_Take) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = {Byte_In, shreg_q[23:8]};
        end
    end

    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            cnt_q   <= 2'd0;
            shreg_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: parses a length-prefixed byte stream and writes words from address 0 upward.
`default_nettype none

module instr_mem_loader
    import rv32_loader_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int MEM_SIZE = 16384
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    instr_mem_loader_if.slave bus
);

    localparam int ADDR_SIZE = $clog2(MEM_SIZE);

    loader_state_t        state_q, state_d;
    logic                 hdr_full_q, hdr_full_d;
    logic [31:0]          n_q, n_d;
    logic [ADDR_SIZE:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [DWIDTH-1:0]    wr_data_q, wr_data_d;

    logic                 byte_ready;
    logic                 byte_take;
    logic                 pk_clear;
    logic                 word_full;
    logic [31:0]          word_out;

    // Header is latched one cycle before it is judged, so no byte is taken in that cycle.
    assign byte_ready = !bus.Load_Abort &&
                        ((state_q == ST_HDR && !hdr_full_q) || state_q == ST_DATA);
    assign byte_take  = byte_ready && bus.Byte_Valid;

    instr_word_packer u_packer (
        .Clk_Core   (Clk_Core),
        .Rst_Core_N (Rst_Core_N),
        .Clear      (pk_clear),
        .Byte_In    (bus.Byte_In),
        .Byte_Take  (byte_take),
        .Word_Out   (word_out),
        .Word_Full  (word_full)
    );

    always_comb begin
        state_d    = state_q;
        hdr_full_d = hdr_full_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pk_clear   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.Load_Start) begin
                    state_d    = ST_HDR;
                    hdr_full_d = 1'b0;
                    word_cnt_d = '0;
                    wr_addr_d  = '0;
                    pk_clear   = 1'b1;
                end
            end
            ST_HDR: begin
                if (bus.Load_Abort) begin
                    state_d  = ST_ERR;
                    pk_clear = 1'b1;
                end else if (hdr_full_q) begin
                    if (n_q == 32'd0)
                        state_d = ST_DONE;
                    else if (n_q > 32'(MEM_SIZE))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end else if (word_full) begin
                    n_d        = word_out;
                    hdr_full_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (bus.Load_Abort) begin
                    state_d  = ST_ERR;
                    pk_clear = 1'b1;
                end else if (word_full) begin
                    wr_data_d = word_out;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                if (wr_addr_q != ADDR_SIZE'(MEM_SIZE - 1))
                    wr_addr_d = wr_addr_q + 1'b1;
                if (bus.Load_Abort)
                    state_d = ST_ERR;
                else if (word_cnt_d == n_q[ADDR_SIZE:0])
                    state_d = ST_DONE;
                else
                    state_d = ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            state_q    <= ST_IDLE;
            hdr_full_q <= 1'b0;
            n_q        <= '0;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            hdr_full_q <= hdr_full_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.Byte_Ready = byte_ready;
    assign bus.Wr_En      = (state_q == ST_WRITE);
    assign bus.Wr_Addr    = wr_addr_q;
    assign bus.Wr_Data    = wr_data_q;
    assign bus.Load_Busy  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_WRITE);
    assign bus.Core_Hold  = bus.Load_Busy;
    assign bus.Load_Done  = (state_q == ST_DONE);
    assign bus.Load_Err   = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
`default_nettype none

module tb_instr_mem_loader;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    instr_mem_loader_if bus ();

    instr_mem_loader dut (
        .Clk_Core   (clk),
        .Rst_Core_N (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observers of write strobes, byte transfers and hold duration
    logic [13:0] wa [0:15];
    logic [31:0] wd [0:15];
    int nwr     = 0;
    int nacc    = 0;
    int nhold   = 0;
    int rdy_bad = 0;

    always @(posedge clk) begin
        if (bus.Wr_En === 1'b1) begin
            if (nwr < 16) begin
                wa[nwr] = bus.Wr_Addr;
                wd[nwr] = bus.Wr_Data;
            end
            nwr++;
            if (bus.Byte_Ready !== 1'b0) rdy_bad++;
        end
        if (bus.Byte_Valid === 1'b1 && bus.Byte_Ready === 1'b1) nacc++;
        if (bus.Core_Hold === 1'b1) nhold++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        nwr     = 0;
        nacc    = 0;
        nhold   = 0;
        rdy_bad = 0;
    endtask

    task automatic start_load();
        bus.Load_Start = 1'b1;
        step();
        bus.Load_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) step();
        bus.Byte_In    = b;
        bus.Byte_Valid = 1'b1;
        #1;
        waited = 0;
        while (bus.Byte_Ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        chk("byte_ready_wait", {63'd0, bus.Byte_Ready}, 64'd1);
        step();
        bus.Byte_Valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], gaps ? int'($urandom_range(7, 0)) : 0);
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (bus.Load_Done === 1'b1 || bus.Load_Err === 1'b1) break;
            step();
        end
        chk(tag, {63'd0, (bus.Load_Done | bus.Load_Err)}, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {63'd0, bus.Byte_Ready}, 64'd0);
        chk({tag, "_wr_en"}, {63'd0, bus.Wr_En},      64'd0);
        chk({tag, "_addr"},  {50'd0, bus.Wr_Addr},    64'd0);
        chk({tag, "_data"},  {32'd0, bus.Wr_Data},    64'd0);
        chk({tag, "_hold"},  {63'd0, bus.Core_Hold},  64'd0);
        chk({tag, "_busy"},  {63'd0, bus.Load_Busy},  64'd0);
        chk({tag, "_done"},  {63'd0, bus.Load_Done},  64'd0);
        chk({tag, "_err"},   {63'd0, bus.Load_Err},   64'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.Load_Start = 1'b0;
        bus.Load_Abort = 1'b0;
        bus.Byte_In    = 8'h00;
        bus.Byte_Valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk_all_zero("reset");

        // Basic two-word image
        clear_obs();
        start_load();
        chk("basic_hold_rise", {63'd0, bus.Core_Hold}, 64'd1);
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_00B3, 1'b0);
        wait_end("basic_end");
        chk("basic_done",  {63'd0, bus.Load_Done}, 64'd1);
        chk("basic_hold",  {63'd0, bus.Core_Hold}, 64'd0);
        chk("basic_nwr",   64'(nwr), 64'd2);
        chk("basic_a0",    {50'd0, wa[0]}, 64'd0);
        chk("basic_d0",    {32'd0, wd[0]}, 64'h0000_0013);
        chk("basic_a1",    {50'd0, wa[1]}, 64'd1);
        chk("basic_d1",    {32'd0, wd[1]}, 64'h0010_00B3);

        // Empty image
        clear_obs();
        start_load();
        chk("empty_done_clr", {63'd0, bus.Load_Done}, 64'd0);
        send_word(32'h0000_0000, 1'b0);
        wait_end("empty_end");
        chk("empty_done",  {63'd0, bus.Load_Done}, 64'd1);
        chk("empty_nwr",   64'(nwr), 64'd0);
        chk("empty_hold",  64'(nhold), 64'd5);

        // Oversize header N = 16385
        clear_obs();
        start_load();
        send_word(32'h0000_4001, 1'b0);
        wait_end("over_end");
        chk("over_err",  {63'd0, bus.Load_Err},  64'd1);
        chk("over_done", {63'd0, bus.Load_Done}, 64'd0);
        chk("over_nwr",  64'(nwr), 64'd0);
        bus.Byte_Valid = 1'b1;
        bus.Byte_In    = 8'h5A;
        step();
        step();
        step();
        chk("over_ready", {63'd0, bus.Byte_Ready}, 64'd0);
        chk("over_nacc",  64'(nacc), 64'd4);
        bus.Byte_Valid = 1'b0;

        // Restart clears the error; three words with random valid gaps
        clear_obs();
        start_load();
        chk("gap_err_clr", {63'd0, bus.Load_Err}, 64'd0);
        send_word(32'h0000_0003, 1'b1);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_00B3, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        wait_end("gap_end");
        chk("gap_done",    {63'd0, bus.Load_Done}, 64'd1);
        chk("gap_nwr",     64'(nwr), 64'd3);
        chk("gap_d0",      {32'd0, wd[0]}, 64'h0000_0013);
        chk("gap_d1",      {32'd0, wd[1]}, 64'h0010_00B3);
        chk("gap_a2",      {50'd0, wa[2]}, 64'd2);
        chk("gap_d2",      {32'd0, wd[2]}, 64'hDEAD_BEEF);
        chk("gap_nacc",    64'(nacc), 64'd16);
        chk("gap_rdy_wr",  64'(rdy_bad), 64'd0);

        // Abort part-way through the second word
        clear_obs();
        start_load();
        send_word(32'h0000_0002, 1'b0);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        bus.Load_Abort = 1'b1;
        step();
        bus.Load_Abort = 1'b0;
        chk("abort_hold", {63'd0, bus.Core_Hold}, 64'd0);
        chk("abort_err",  {63'd0, bus.Load_Err},  64'd1);
        step();
        step();
        chk("abort_nwr",  64'(nwr), 64'd1);
        chk("abort_a0",   {50'd0, wa[0]}, 64'd0);
        chk("abort_d0",   {32'd0, wd[0]}, 64'h4433_2211);

        // Reset during DATA, then a fresh one-word load
        clear_obs();
        start_load();
        send_word(32'h0000_0001, 1'b0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_all_zero("midrst");
        clear_obs();
        start_load();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hDDCC_BBAA, 1'b0);
        wait_end("fresh_end");
        chk("fresh_done", {63'd0, bus.Load_Done}, 64'd1);
        chk("fresh_nwr",  64'(nwr), 64'd1);
        chk("fresh_a0",   {50'd0, wa[0]}, 64'd0);
        chk("fresh_d0",   {32'd0, wd[0]}, 64'hDDCC_BBAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
